// File: rtl/aibnd_txdat_stage.sv
// TX data stage: IDLE -> TRAIN -> RUN sequencer that registers either a
// training preamble, core data, or an internal test pattern onto the TX bus
// feeding the downstream delay-mimic stage. Every output is a flop.
module aibnd_txdat_stage #(
  parameter int DW       = 40,
  parameter int WARM_CYC = 16
) (
  input  logic          ihssi_tx_clk,
  input  logic          ihssi_tx_rst,
  input  logic [DW-1:0] idat_core,
  input  logic          idat_vld,
  input  logic          csr_tx_en,
  input  logic          csr_pat_en,
  input  logic [1:0]    csr_pat_sel,
  output logic [DW-1:0] ihssi_tx_data_out,
  output logic          tx_dat_rdy,
  output logic          tx_underrun
);

  // state | meaning
  // IDLE  | TX disabled, bus driven to zero, underrun cleared
  // TRAIN | WARM_CYC cycles of alternating AA../55.. preamble
  // RUN   | core data or internal test pattern on the bus
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRAIN = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  localparam logic [DW-1:0] WORD_A     = {(DW/2){2'b10}};
  localparam logic [DW-1:0] WORD_ONES  = {DW{1'b1}};
  localparam logic [DW-1:0] WALK_INIT  = {{(DW-1){1'b0}}, 1'b1};
  localparam logic [8:0]    TRAIN_LAST = 9'(WARM_CYC - 1);

  state_t          state;
  state_t          state_nxt;
  logic [8:0]      train_cnt;
  logic [7:0]      cnt8;
  logic [DW-1:0]   walk;
  logic [DW-1:0]   tog;
  logic [1:0]      sel_q;

  logic            run_stay;
  logic            pat_active;
  logic            sel_chg;
  logic [7:0]      cnt8_eff;
  logic [DW-1:0]   walk_eff;
  logic [DW-1:0]   tog_eff;
  logic [DW-1:0]   pat_word;

  // Next-state decode; a low enable wins over every other transition.
  always_comb begin
    state_nxt = state;
    if (!csr_tx_en) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  state_nxt = ST_TRAIN;
        ST_TRAIN: if (train_cnt == TRAIN_LAST) state_nxt = ST_RUN;
        ST_RUN:   state_nxt = ST_RUN;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge ihssi_tx_clk or posedge ihssi_tx_rst) begin
    if (ihssi_tx_rst) state <= ST_IDLE;
    else              state <= state_nxt;
  end

  // Train counter: zero outside TRAIN so it is already clear on entry.
  always_ff @(posedge ihssi_tx_clk or posedge ihssi_tx_rst) begin
    if (ihssi_tx_rst) train_cnt <= '0;
    else if (state == ST_TRAIN && state_nxt == ST_TRAIN) train_cnt <= train_cnt + 9'd1;
    else train_cnt <= '0;
  end

  // Pattern selection: a select change restarts from the new pattern's
  // initial word on the very edge that sees the change.
  always_comb begin
    run_stay   = (state == ST_RUN) && (state_nxt == ST_RUN);
    pat_active = run_stay && csr_pat_en;
    sel_chg    = (csr_pat_sel != sel_q);
    cnt8_eff   = sel_chg ? 8'd0 : cnt8;
    walk_eff   = sel_chg ? WALK_INIT : walk;
    tog_eff    = sel_chg ? WORD_A : tog;
    pat_word   = '0;
    case (csr_pat_sel)
      2'd0:    pat_word = {(DW/8){cnt8_eff}};
      2'd1:    pat_word = walk_eff;
      2'd2:    pat_word = tog_eff;
      default: pat_word = WORD_ONES;
    endcase
  end

  // Pattern generator state holds the next word; idle whenever not emitting.
  always_ff @(posedge ihssi_tx_clk or posedge ihssi_tx_rst) begin
    if (ihssi_tx_rst) begin
      cnt8 <= 8'd0;
      walk <= WALK_INIT;
      tog  <= WORD_A;
    end else if (pat_active) begin
      cnt8 <= cnt8_eff + 8'd1;
      walk <= {walk_eff[DW-2:0], walk_eff[DW-1]};
      tog  <= ~tog_eff;
    end else begin
      cnt8 <= 8'd0;
      walk <= WALK_INIT;
      tog  <= WORD_A;
    end
  end

  // Previous select, used to detect a select change.
  always_ff @(posedge ihssi_tx_clk or posedge ihssi_tx_rst) begin
    if (ihssi_tx_rst) sel_q <= 2'd0;
    else              sel_q <= csr_pat_sel;
  end

  // Output word keyed on the state being entered. The TRAIN->RUN edge holds
  // the last preamble word: RUN data rules apply only from the first RUN cycle.
  always_ff @(posedge ihssi_tx_clk or posedge ihssi_tx_rst) begin
    if (ihssi_tx_rst) begin
      ihssi_tx_data_out <= '0;
    end else begin
      case (state_nxt)
        ST_TRAIN: ihssi_tx_data_out <= (state == ST_TRAIN) ? ~ihssi_tx_data_out : WORD_A;
        ST_RUN: begin
          if (state == ST_RUN) begin
            if (csr_pat_en)    ihssi_tx_data_out <= pat_word;
            else if (idat_vld) ihssi_tx_data_out <= idat_core;
          end
        end
        default:  ihssi_tx_data_out <= '0;
      endcase
    end
  end

  // Ready flag mirrors the RUN state.
  always_ff @(posedge ihssi_tx_clk or posedge ihssi_tx_rst) begin
    if (ihssi_tx_rst) tx_dat_rdy <= 1'b0;
    else              tx_dat_rdy <= (state_nxt == ST_RUN);
  end

  // Sticky underrun: set on missing core data in RUN, cleared only in IDLE.
  always_ff @(posedge ihssi_tx_clk or posedge ihssi_tx_rst) begin
    if (ihssi_tx_rst) tx_underrun <= 1'b0;
    else if (state_nxt == ST_IDLE) tx_underrun <= 1'b0;
    else if (run_stay && !csr_pat_en && !idat_vld) tx_underrun <= 1'b1;
  end

endmodule

// File: tb/tb_aibnd_txdat_stage.sv
// Self-checking bench for aibnd_txdat_stage: vector table for training and
// core-data behaviour, hand sequences for patterns, reset and enable priority.
module tb_aibnd_txdat_stage;

  localparam int DW = 40;
  localparam int WC = 16;

  logic          clk;
  logic          rst;
  logic [DW-1:0] core;
  logic          vld;
  logic          tx_en;
  logic          pat_en;
  logic [1:0]    sel;
  logic [DW-1:0] dout;
  logic          rdy;
  logic          und;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          tx_en;
    logic          pat_en;
    logic [1:0]    sel;
    logic          vld;
    logic [DW-1:0] core;
    logic [DW-1:0] exp_d;
    logic          exp_rdy;
    logic          exp_und;
  } vec_t;

  vec_t vecs[$];

  aibnd_txdat_stage #(.DW(DW), .WARM_CYC(WC)) dut (
    .ihssi_tx_clk      (clk),
    .ihssi_tx_rst      (rst),
    .idat_core         (core),
    .idat_vld          (vld),
    .csr_tx_en         (tx_en),
    .csr_pat_en        (pat_en),
    .csr_pat_sel       (sel),
    .ihssi_tx_data_out (dout),
    .tx_dat_rdy        (rdy),
    .tx_underrun       (und)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [DW-1:0] ed, input logic er, input logic eu);
    chk({name, ".data"}, dout, ed);
    chk({name, ".rdy"}, {39'd0, rdy}, {39'd0, er});
    chk({name, ".und"}, {39'd0, und}, {39'd0, eu});
  endtask

  task automatic add(input logic te, input logic pe, input logic [1:0] s, input logic v,
                     input logic [DW-1:0] c, input logic [DW-1:0] ed, input logic er, input logic eu);
    vec_t t;
    t.tx_en = te; t.pat_en = pe; t.sel = s; t.vld = v; t.core = c;
    t.exp_d = ed; t.exp_rdy = er; t.exp_und = eu;
    vecs.push_back(t);
  endtask

  localparam logic [DW-1:0] WA = 40'hAAAAAAAAAA;
  localparam logic [DW-1:0] W5 = 40'h5555555555;
  localparam logic [DW-1:0] WF = 40'hFFFFFFFFFF;

  initial begin
    logic [DW-1:0] w;
    logic [7:0]    c8;

    // training preamble, RUN entry, core data, underrun, disable
    for (int i = 0; i < WC; i++) add(1, 0, 0, 0, '0, (i % 2 == 0) ? WA : W5, 0, 0);
    add(1, 0, 0, 0, '0,            W5,            1, 0);
    add(1, 0, 0, 1, 40'h0123456789, 40'h0123456789, 1, 0);
    add(1, 0, 0, 1, 40'hFEDCBA9876, 40'hFEDCBA9876, 1, 0);
    add(1, 0, 0, 0, 40'h1111111111, 40'hFEDCBA9876, 1, 1);
    add(1, 0, 0, 0, 40'h1111111111, 40'hFEDCBA9876, 1, 1);
    add(1, 0, 0, 0, 40'h1111111111, 40'hFEDCBA9876, 1, 1);
    add(1, 0, 0, 1, 40'h0A0B0C0D0E, 40'h0A0B0C0D0E, 1, 1);
    add(0, 0, 0, 1, 40'h2222222222, '0,            0, 0);
    add(0, 0, 0, 1, 40'h2222222222, '0,            0, 0);

    rst = 1'b1; core = '0; vld = 0; tx_en = 0; pat_en = 0; sel = 0;
    #1;
    chk_all("reset", '0, 0, 0);
    step(); step();
    rst = 1'b0;
    step();
    chk_all("idle_after_reset", '0, 0, 0);

    foreach (vecs[i]) begin
      tx_en = vecs[i].tx_en; pat_en = vecs[i].pat_en; sel = vecs[i].sel;
      vld = vecs[i].vld; core = vecs[i].core;
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].exp_d, vecs[i].exp_rdy, vecs[i].exp_und);
    end

    // walking-one with wrap
    tx_en = 1; pat_en = 1; sel = 1; vld = 0; core = '0;
    for (int i = 0; i < WC + 1; i++) step();
    chk_all("walk_entry", W5, 1, 0);
    w = 40'h1;
    for (int i = 0; i < 42; i++) begin
      step();
      chk($sformatf("walk%0d", i), dout, w);
      w = {w[DW-2:0], w[DW-1]};
    end
    chk({"walk_und"}, {39'd0, und}, 40'd0);

    // counter wrap after select change
    sel = 0;
    c8 = 8'd0;
    for (int i = 0; i < 257; i++) begin
      step();
      chk($sformatf("cnt%0d", i), dout, {5{c8}});
      c8 = c8 + 8'd1;
    end
    sel = 2;
    step(); chk("tog0", dout, WA);
    step(); chk("tog1", dout, W5);
    step(); chk("tog2", dout, WA);
    sel = 3;
    step(); chk("ones0", dout, WF);
    step(); chk("ones1", dout, WF);

    // pattern off -> core data, underrun, pattern ignores vld
    pat_en = 0; vld = 1; core = 40'h123456789A;
    step(); chk_all("pat_off_core", 40'h123456789A, 1, 0);
    vld = 0;
    step(); chk_all("pat_off_hold", 40'h123456789A, 1, 1);
    pat_en = 1;
    step(); chk_all("pat_keeps_und", WF, 1, 1);
    sel = 1;
    step(); chk("walk_restart0", dout, 40'h1);
    step(); chk("walk_restart1", dout, 40'h2);
    pat_en = 0; vld = 1; core = 40'h0000000C00;
    step(); chk("pat_gap_core", dout, 40'h0000000C00);
    pat_en = 1;
    step(); chk("walk_reinit", dout, 40'h1);

    // asynchronous reset in RUN
    vld = 0; pat_en = 0;
    step(); chk("und_before_rst", {39'd0, und}, 40'd1);
    #3 rst = 1'b1;
    #1;
    chk_all("async_rst", '0, 0, 0);
    step(); step();
    tx_en = 1; pat_en = 0;
    rst = 1'b0;
    step(); chk_all("retrain0", WA, 0, 0);

    // enable falls as the train counter reaches its last value
    for (int i = 1; i < WC; i++) step();
    chk_all("train_last", W5, 0, 0);
    tx_en = 0;
    step(); chk_all("prio_idle0", '0, 0, 0);
    step(); chk_all("prio_idle1", '0, 0, 0);
    tx_en = 1;
    step(); chk_all("retrain1", WA, 0, 0);
    for (int i = 1; i < WC; i++) step();
    chk_all("retrain_last", W5, 0, 0);
    step(); chk_all("retrain_run", W5, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
